// File: rtl/clkgate_ctrl.sv
// Per-domain clock-gate controller for CLKGATE_X4 E pins; gates after IDLE_CYC idle cycles, wakes via activity or req/ack.
// Latency: E falls IDLE_CYC edges after idle enters IDLE; E rises the edge act is seen in OFF, wake_ack WAKE_CYC edges later.
// Backpressure: wake_req is held by the requester until wake_ack; a held wake_req keeps the domain out of IDLE.
// Optional feature macro: CGC_FORCE_ON_EN adds a global force_on input that counts as activity for every domain.
module clkgate_ctrl #(
    parameter int N_DOM    = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [N_DOM-1:0] busy,
    input  logic [N_DOM-1:0] wake_req,
`ifdef CGC_FORCE_ON_EN
    input  logic             force_on,
`endif
    output logic [N_DOM-1:0] wake_ack,
    output logic [N_DOM-1:0] E,
    output logic [N_DOM-1:0] gated
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

    state_t           state_q [N_DOM];
    state_t           state_d [N_DOM];
    logic [CNT_W-1:0] cnt_q   [N_DOM];
    logic [CNT_W-1:0] cnt_d   [N_DOM];
    logic [N_DOM-1:0] e_q, e_d;
    logic [N_DOM-1:0] gated_q, gated_d;
    logic [N_DOM-1:0] ack_q, ack_d;
    logic [N_DOM-1:0] act;

`ifdef CGC_FORCE_ON_EN
    assign act = busy | wake_req | {N_DOM{force_on}};
`else
    assign act = busy | wake_req;
`endif

    // Next state per domain; outputs are derived from the next state so they are registered alongside it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = '0;
        gated_d = '0;
        ack_d   = '0;
        for (int d = 0; d < N_DOM; d++) begin
            unique case (state_q[d])
                ST_RUN: begin
                    if (!act[d]) begin
                        state_d[d] = ST_IDLE;
                        cnt_d[d]   = '0;
                    end
                end
                ST_IDLE: begin
                    // Activity wins even on the terminal-count edge.
                    if (act[d]) begin
                        state_d[d] = ST_RUN;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == IDLE_LAST) begin
                        state_d[d] = ST_OFF;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + 1'b1;
                    end
                end
                ST_OFF: begin
                    if (act[d]) begin
                        state_d[d] = ST_WAKE;
                        cnt_d[d]   = '0;
                    end
                end
                ST_WAKE: begin
                    // Settle delay runs to completion regardless of act.
                    if (cnt_q[d] == WAKE_LAST) begin
                        state_d[d] = ST_RUN;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + 1'b1;
                    end
                end
                default: begin
                    state_d[d] = ST_RUN;
                    cnt_d[d]   = '0;
                end
            endcase
            e_d[d]     = (state_d[d] != ST_OFF);
            gated_d[d] = (state_d[d] == ST_OFF);
            ack_d[d]   = (state_d[d] == ST_RUN) && wake_req[d];
        end
    end

    // State, counters and output flops; reset leaves every clock running so gated logic resets too.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            for (int d = 0; d < N_DOM; d++) begin
                state_q[d] <= ST_RUN;
                cnt_q[d]   <= '0;
            end
            e_q     <= '1;
            gated_q <= '0;
            ack_q   <= '0;
        end else begin
            for (int d = 0; d < N_DOM; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
            e_q     <= e_d;
            gated_q <= gated_d;
            ack_q   <= ack_d;
        end
    end

    assign E        = e_q;
    assign gated    = gated_q;
    assign wake_ack = ack_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
module tb_clkgate_ctrl;

    localparam int N  = 4;
    localparam int IC = 16;
    localparam int WC = 2;

    logic         CK = 1'b0;
    logic         RN;
    logic [N-1:0] busy;
    logic [N-1:0] wake_req;
`ifdef CGC_FORCE_ON_EN
    logic         force_on;
`endif
    logic [N-1:0] wake_ack;
    logic [N-1:0] E;
    logic [N-1:0] gated;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per domain, either gated, waking (edges left), or running with a count of consecutive idle samples.
    bit m_off  [N];
    int m_idle [N];
    int m_wl   [N];
    bit m_ack  [N];

    clkgate_ctrl #(.N_DOM(N), .IDLE_CYC(IC), .WAKE_CYC(WC), .CNT_W(8)) dut (
        .CK       (CK),
        .RN       (RN),
        .busy     (busy),
        .wake_req (wake_req),
`ifdef CGC_FORCE_ON_EN
        .force_on (force_on),
`endif
        .wake_ack (wake_ack),
        .E        (E),
        .gated    (gated)
    );

    always #5 CK = ~CK;

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_off[d] = 0; m_idle[d] = 0; m_wl[d] = 0; m_ack[d] = 0;
        end
    endtask

    task automatic model_step();
        bit a;
        for (int d = 0; d < N; d++) begin
            a = busy[d] | wake_req[d];
`ifdef CGC_FORCE_ON_EN
            a = a | force_on;
`endif
            if (m_wl[d] > 0) begin
                m_wl[d]--;
                m_ack[d] = (m_wl[d] == 0) && wake_req[d];
                m_idle[d] = 0;
            end else if (m_off[d]) begin
                m_ack[d] = 0;
                if (a) begin
                    m_off[d] = 0;
                    m_wl[d]  = WC;
                end
            end else if (a) begin
                m_idle[d] = 0;
                m_ack[d]  = wake_req[d];
            end else begin
                m_ack[d] = 0;
                m_idle[d]++;
                // The first idle sample enters IDLE; IC further idle samples gate the clock.
                if (m_idle[d] == IC + 1) begin
                    m_off[d]  = 1;
                    m_idle[d] = 0;
                end
            end
        end
    endtask

    function automatic logic [3*N-1:0] model_out();
        logic [N-1:0] e, g, k;
        for (int d = 0; d < N; d++) begin
            e[d] = !m_off[d];
            g[d] = m_off[d];
            k[d] = m_ack[d];
        end
        return {e, g, k};
    endfunction

    task automatic tick();
        @(posedge CK);
        model_step();
        @(negedge CK);
    endtask

    task automatic run_all();
        busy = '1;
        wake_req = '0;
`ifdef CGC_FORCE_ON_EN
        force_on = 1'b0;
`endif
        repeat (WC + 2) tick();
    endtask

    task automatic test_reset();
        RN = 1'b1; busy = '0; wake_req = '0;
`ifdef CGC_FORCE_ON_EN
        force_on = 1'b0;
`endif
        #2 RN = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({E, gated, wake_ack} !== {4'hF, 4'h0, 4'h0}) begin
            n_bad++; $display("FAIL reset_async got=%h exp=%h", {E, gated, wake_ack}, {4'hF, 4'h0, 4'h0});
        end
        @(posedge CK); @(negedge CK);
        n_cmp++;
        if ({E, gated, wake_ack} !== {4'hF, 4'h0, 4'h0}) begin
            n_bad++; $display("FAIL reset_held got=%h exp=%h", {E, gated, wake_ack}, {4'hF, 4'h0, 4'h0});
        end
        RN = 1'b1;
        repeat (IC) tick();
        n_cmp++;
        if (E !== 4'hF || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL gate_before got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        tick();
        n_cmp++;
        if (E !== 4'h0 || gated !== 4'hF || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL gate_after got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
    endtask

    task automatic test_idle_abort();
        run_all();
        busy = 4'hE;
        repeat (10) tick();
        busy = 4'hF;
        tick();
        n_cmp++;
        if (E[0] !== 1'b1 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL abort_run got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        busy = 4'hE;
        repeat (IC) tick();
        n_cmp++;
        if (E[0] !== 1'b1 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL abort_full_run got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        tick();
        n_cmp++;
        if (E[0] !== 1'b0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL abort_regate got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
    endtask

    task automatic test_terminal_race();
        run_all();
        busy = 4'hD;
        repeat (IC) tick();
        busy = 4'hF;
        tick();
        n_cmp++;
        if (E[1] !== 1'b1 || gated[1] !== 1'b0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL race_edge got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        repeat (3) tick();
        n_cmp++;
        if (gated[1] !== 1'b0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL race_after got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
    endtask

    task automatic test_wake_handshake();
        run_all();
        busy = 4'hB;
        repeat (IC + 1) tick();
        n_cmp++;
        if (gated[2] !== 1'b1 || E[2] !== 1'b0) begin
            n_bad++; $display("FAIL wake_setup got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        wake_req = 4'h4;
        tick();
        n_cmp++;
        if (E[2] !== 1'b1 || wake_ack[2] !== 1'b0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL wake_t0 got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        tick();
        n_cmp++;
        if (wake_ack[2] !== 1'b0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL wake_t1 got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        tick();
        n_cmp++;
        if (wake_ack[2] !== 1'b1 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL wake_t2 got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        tick();
        n_cmp++;
        if (wake_ack[2] !== 1'b1 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL wake_hold got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        wake_req = '0;
        tick();
        n_cmp++;
        if (wake_ack[2] !== 1'b0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL wake_release got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
    endtask

    task automatic test_reset_mid_wake();
        run_all();
        busy = 4'h7;
        repeat (IC + 1) tick();
        wake_req = 4'h8;
        tick();
        tick();
        RN = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({E, gated, wake_ack} !== {4'hF, 4'h0, 4'h0}) begin
            n_bad++; $display("FAIL midwake_reset got=%h exp=%h", {E, gated, wake_ack}, {4'hF, 4'h0, 4'h0});
        end
        @(negedge CK);
        RN = 1'b1;
        wake_req = '0;
        repeat (IC) tick();
        n_cmp++;
        if (E[3] !== 1'b1 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL midwake_count got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        tick();
        n_cmp++;
        if (E[3] !== 1'b0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL midwake_gate got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
    endtask

`ifdef CGC_FORCE_ON_EN
    task automatic test_force_on();
        run_all();
        busy = '0;
        repeat (IC + 1) tick();
        force_on = 1'b1;
        tick();
        n_cmp++;
        if (E !== 4'hF || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL force_rise got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        repeat (8) tick();
        n_cmp++;
        if (E !== 4'hF || gated !== 4'h0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL force_hold got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        force_on = 1'b0;
        repeat (IC) tick();
        n_cmp++;
        if (E !== 4'hF || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL force_release got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
        tick();
        n_cmp++;
        if (E !== 4'h0 || {E, gated, wake_ack} !== model_out()) begin
            n_bad++; $display("FAIL force_regate got=%h exp=%h", {E, gated, wake_ack}, model_out());
        end
    endtask
`endif

    task automatic test_random();
        int bad_here;
        bad_here = 0;
        run_all();
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 24) == 0) busy[d] = ~busy[d];
                if (!wake_req[d] && $urandom_range(0, 29) == 0) wake_req[d] = 1'b1;
                else if (wake_req[d] && m_ack[d] && $urandom_range(0, 2) == 0) wake_req[d] = 1'b0;
            end
            tick();
            n_cmp++;
            if ({E, gated, wake_ack} !== model_out()) begin
                n_bad++;
                bad_here++;
                if (bad_here <= 10)
                    $display("FAIL random cyc=%0d got=%h exp=%h", c, {E, gated, wake_ack}, model_out());
            end
        end
    endtask

    initial begin
        busy = '0;
        wake_req = '0;
        test_reset();
        test_idle_abort();
        test_terminal_race();
        test_wake_handshake();
        test_reset_mid_wake();
`ifdef CGC_FORCE_ON_EN
        test_force_on();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
